hazard_scoreboard: RTL

Parametrised scoreboard-based hazard unit for the 5-stage RISC-V pipeline, sitting beside the ID stage. Tracks every in-flight register write with a per-register countdown, so stalls follow the actual producer-to-consumer distance instead of a single EX-stage load check. Raises flush on a redirected PC in EX and keeps saturating stall/flush performance counters.

---
 rtl/hazard_scoreboard.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit beside ID: per-register countdowns drive RAW stalls, an EX redirect drives flush.
// Latency: stall/flush are combinational from ID/EX and registered counters; new marks land on the issuing edge.
// Backpressure: stall holds PC and IF/ID; flush overrides stall. Optional macro HAZARD_FWD_EN selects the forwarding model.
module hazard_scoreboard #(
  parameter int DATA_WIDTH   = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int WB_LAT       = 3,
  parameter int LOAD_USE_LAT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic [6:0]                   id_opcode,
  input  logic [REG_ADDR_W-1:0]        id_rs1,
  input  logic [REG_ADDR_W-1:0]        id_rs2,
  input  logic [REG_ADDR_W-1:0]        id_rd,
  input  logic                         ex_valid,
  input  logic [DATA_WIDTH-1:0]        ex_pc_plus_4,
  input  logic [DATA_WIDTH-1:0]        ex_pc_target,
  output logic                         flush,
  output logic                         stall,
  output logic [(1<<REG_ADDR_W)-1:0]   busy_mask,
  output logic [DATA_WIDTH-1:0]        stall_cycles,
  output logic [DATA_WIDTH-1:0]        flush_count
);

  localparam int NREG  = 1 << REG_ADDR_W;
  localparam int CNT_W = $clog2(WB_LAT + 1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  if (WB_LAT < 1 || WB_LAT > 7) begin : g_bad_wb_lat
    $error("hazard_scoreboard: WB_LAT must be 1..7");
  end
  if (LOAD_USE_LAT < 1 || LOAD_USE_LAT > WB_LAT) begin : g_bad_lu_lat
    $error("hazard_scoreboard: LOAD_USE_LAT must be 1..WB_LAT");
  end

  logic [CNT_W-1:0]      cnt_q [NREG];
  logic [CNT_W-1:0]      cnt_d [NREG];
  logic [CNT_W-1:0]      dec_cnt [NREG];
  logic [DATA_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
  logic [DATA_WIDTH-1:0] flush_count_q, flush_count_d;

  logic use_rs1, use_rs2, writes;
  logic rs1_busy, rs2_busy, raw, issue;
  logic [CNT_W-1:0] set_lat;

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    writes  = 1'b0;
    case (id_opcode)
      OP_R:     begin use_rs1 = 1'b1; use_rs2 = 1'b1; writes = 1'b1; end
      OP_I:     begin use_rs1 = 1'b1; writes = 1'b1; end
      OP_LOAD:  begin use_rs1 = 1'b1; writes = 1'b1; end
      OP_STORE: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_BR:    begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_JAL:   writes = 1'b1;
      OP_JALR:  begin use_rs1 = 1'b1; writes = 1'b1; end
      OP_LUI:   writes = 1'b1;
      OP_AUIPC: writes = 1'b1;
      default:  ;
    endcase
  end

`ifdef HAZARD_FWD_EN
  // Forwarding covers ALU results; only a load's data arrives too late for the consumer in ID.
  logic is_load;
  assign is_load = (id_opcode == OP_LOAD);
  assign set_lat = is_load ? CNT_W'(LOAD_USE_LAT) : '0;
`else
  assign set_lat = CNT_W'(WB_LAT);
`endif

  assign rs1_busy = use_rs1 && (id_rs1 != '0) && (cnt_q[id_rs1] != '0);
  assign rs2_busy = use_rs2 && (id_rs2 != '0) && (cnt_q[id_rs2] != '0);
  assign raw      = id_valid && (rs1_busy || rs2_busy);

  assign flush = ex_valid && (ex_pc_plus_4 != ex_pc_target);
  assign stall = raw && !flush;
  assign issue = id_valid && !stall && !flush && writes && (id_rd != '0);

  // A newer writer to the same register may only lengthen the pending wait.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      dec_cnt[r] = (cnt_q[r] != '0) ? (cnt_q[r] - CNT_W'(1)) : '0;
      cnt_d[r]   = dec_cnt[r];
      if (issue && (id_rd == REG_ADDR_W'(r)) && (set_lat > dec_cnt[r])) begin
        cnt_d[r] = set_lat;
      end
    end
    cnt_d[0] = '0;
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      busy_mask[r] = (cnt_q[r] != '0);
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (stall && (stall_cycles_q != {DATA_WIDTH{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + DATA_WIDTH'(1);
    end
    if (flush && (flush_count_q != {DATA_WIDTH{1'b1}})) begin
      flush_count_d = flush_count_q + DATA_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

  a_flush_over_stall: assert property (@(posedge clk) !(stall && flush));

endmodule
